neuron_mac_sequencer: RTL and testbench

Sequenced replacement for the combinational neuron sum. It stores input values A and weights B in two on-chip arrays loaded through a write port, then runs a serial multiply-accumulate over all N entries, one entry per clock. It produces the signed dot product, the zero/positive/negative flags and the encoded class. It sits between the serial shift-register front end (ADDR/DATA/RS word) and the downstream logic that consumes the classification.

---
 rtl/neuron_mac_if.sv | 28 ++
 rtl/neuron_mac_sequencer.sv | 111 +++++++++++
 tb/tb_neuron_mac_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_if.sv
// Write port, run control and result bus of the neuron MAC sequencer.
interface neuron_mac_if #(
    parameter int unsigned DW   = 8,
    parameter int unsigned AW   = 9,
    parameter int unsigned ACCW = 26
);
    logic                   wr;
    logic                   rs;
    logic [AW-1:0]          addr;
    logic signed [DW-1:0]   data;
    logic                   wr_ready;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic signed [ACCW-1:0] sum;
    logic [2:0]             check;
    logic [1:0]             checkP;

    modport master (
        output wr, rs, addr, data, start,
        input  wr_ready, busy, done, sum, check, checkP
    );

    modport slave (
        input  wr, rs, addr, data, start,
        output wr_ready, busy, done, sum, check, checkP
    );
endinterface

// File: rtl/neuron_mac_sequencer.sv
// Serial multiply-accumulate over N stored (A, B) entry pairs, one entry per clock,
// producing the signed dot product plus its sign flags and class code.
module neuron_mac_sequencer #(
    parameter int unsigned N    = 400,
    parameter int unsigned DW   = 8,
    parameter int unsigned AW   = 9,
    parameter int unsigned ACCW = 26
) (
    input  logic        clk_,
    input  logic        rst,
    neuron_mac_if.slave bus
);
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [AW-1:0]          idx;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] sum_q;
    logic [2:0]             check_q;
    logic [1:0]             checkp_q;
    logic                   done_q;
    logic                   busy_q;
    logic                   wr_ready_q;

    logic signed [DW-1:0]   mem_a [N];
    logic signed [DW-1:0]   mem_b [N];

    logic signed [PW-1:0]   prod_c;
    logic signed [ACCW-1:0] acc_next_c;
    logic                   zero_c;
    logic                   neg_c;
    logic                   last_c;

    // Full-width signed product of the current entry, sign-extended into the accumulator.
    assign prod_c     = PW'(mem_a[idx[IW-1:0]]) * PW'(mem_b[idx[IW-1:0]]);
    assign acc_next_c = acc + {{(ACCW-PW){prod_c[PW-1]}}, prod_c};
    assign zero_c     = (acc_next_c == '0);
    assign neg_c      = acc_next_c[ACCW-1];
    assign last_c     = (idx == AW'(N - 1));

    // Array writes land only outside RUN; out-of-range addresses are dropped.
    always_ff @(posedge clk_) begin
        if (!rst && bus.wr && (state != RUN) && (32'(bus.addr) < N)) begin
            if (bus.rs) begin
                mem_b[bus.addr[IW-1:0]] <= bus.data;
            end else begin
                mem_a[bus.addr[IW-1:0]] <= bus.data;
            end
        end
    end

    // Sequencer FSM with registered result and status outputs.
    always_ff @(posedge clk_) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            acc        <= '0;
            sum_q      <= '0;
            check_q    <= 3'b000;
            checkp_q   <= 2'd0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state      <= RUN;
                        idx        <= '0;
                        acc        <= '0;
                        busy_q     <= 1'b1;
                        wr_ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    acc <= acc_next_c;
                    idx <= idx + AW'(1);
                    if (last_c) begin
                        state      <= DONE;
                        sum_q      <= acc_next_c;
                        check_q    <= {neg_c, !neg_c && !zero_c, zero_c};
                        checkp_q   <= zero_c ? 2'd1 : (neg_c ? 2'd3 : 2'd2);
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        wr_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy_q     <= 1'b0;
                    wr_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.sum      = sum_q;
    assign bus.check    = check_q;
    assign bus.checkP   = checkp_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.wr_ready = wr_ready_q;
endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed bench: a 4-entry sequencer for functional cases and a 400-entry one for full scale.
module tb_neuron_mac_sequencer;
    logic clk_;
    logic rst;
    int   n_checks;
    int   n_fail;

    neuron_mac_if #(.DW(8), .AW(9), .ACCW(26)) b4 ();
    neuron_mac_if #(.DW(8), .AW(9), .ACCW(26)) b400 ();

    neuron_mac_sequencer #(.N(4), .DW(8), .AW(9), .ACCW(26)) dut4 (
        .clk_(clk_), .rst(rst), .bus(b4)
    );
    neuron_mac_sequencer #(.N(400), .DW(8), .AW(9), .ACCW(26)) dut400 (
        .clk_(clk_), .rst(rst), .bus(b400)
    );

    initial clk_ = 1'b0;
    always #5 clk_ = ~clk_;

    task automatic tick();
        @(posedge clk_);
        #1;
    endtask

    task automatic write4(input logic sel, input int a, input int d);
        b4.wr = 1'b1; b4.rs = sel; b4.addr = 9'(a); b4.data = 8'(d);
        tick();
        b4.wr = 1'b0;
    endtask

    task automatic load4(input int a0, input int a1, input int a2, input int a3,
                         input int w0, input int w1, input int w2, input int w3);
        write4(1'b0, 0, a0); write4(1'b0, 1, a1); write4(1'b0, 2, a2); write4(1'b0, 3, a3);
        write4(1'b1, 0, w0); write4(1'b1, 1, w1); write4(1'b1, 2, w2); write4(1'b1, 3, w3);
    endtask

    // Pulse start for one edge and count cycles until done (-1 if never within budget).
    task automatic run4(output int lat);
        b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (b4.done) begin lat = k; break; end
        end
    endtask

    task automatic test_reset();
        int lat;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        n_checks++; if (b4.busy !== 1'b0 || b4.done !== 1'b0 || b4.wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_status: busy=%b done=%b wr_ready=%b expected 0 0 1", b4.busy, b4.done, b4.wr_ready); end
        n_checks++; if (b4.sum !== 26'sd0 || b4.check !== 3'b000 || b4.checkP !== 2'd0) begin
            n_fail++; $display("FAIL reset_result: sum=%0d check=%b checkP=%0d expected 0 000 0", b4.sum, b4.check, b4.checkP); end
        load4(1, 2, 3, 4, 1, 1, 1, 1);
        b4.start = 1'b1; tick(); b4.start = 1'b0; tick();
        n_checks++; if (b4.busy !== 1'b1 || b4.wr_ready !== 1'b0) begin
            n_fail++; $display("FAIL run_busy: busy=%b wr_ready=%b expected 1 0", b4.busy, b4.wr_ready); end
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        n_checks++; if (b4.busy !== 1'b0 || b4.done !== 1'b0 || b4.wr_ready !== 1'b1 ||
                        b4.sum !== 26'sd0 || b4.check !== 3'b000 || b4.checkP !== 2'd0) begin
            n_fail++; $display("FAIL reset_mid_run: busy=%b done=%b wr_ready=%b sum=%0d check=%b checkP=%0d expected 0 0 1 0 000 0",
                               b4.busy, b4.done, b4.wr_ready, b4.sum, b4.check, b4.checkP); end
        lat = 0;
        for (int k = 0; k < 8; k++) begin tick(); if (b4.done) lat++; end
        n_checks++; if (lat != 0) begin
            n_fail++; $display("FAIL reset_no_done: %0d done pulses expected 0", lat); end
    endtask

    task automatic test_positive();
        int lat;
        load4(1, 2, 3, 4, 1, 1, 1, 1);
        run4(lat);
        n_checks++; if (lat != 4) begin n_fail++; $display("FAIL pos_latency: %0d expected 4", lat); end
        n_checks++; if (b4.sum !== 26'sd10 || b4.check !== 3'b010 || b4.checkP !== 2'd2 || b4.busy !== 1'b0) begin
            n_fail++; $display("FAIL pos_result: sum=%0d check=%b checkP=%0d busy=%b expected 10 010 2 0", b4.sum, b4.check, b4.checkP, b4.busy); end
        tick();
        n_checks++; if (b4.done !== 1'b0 || b4.sum !== 26'sd10) begin
            n_fail++; $display("FAIL done_pulse_width: done=%b sum=%0d expected 0 10", b4.done, b4.sum); end
    endtask

    task automatic test_negative();
        int lat;
        load4(-128, -128, -128, -128, 127, 127, 127, 127);
        run4(lat);
        n_checks++; if (lat != 4 || b4.sum !== -26'sd65024 || b4.check !== 3'b100 || b4.checkP !== 2'd3) begin
            n_fail++; $display("FAIL neg_result: lat=%0d sum=%0d check=%b checkP=%0d expected 4 -65024 100 3", lat, b4.sum, b4.check, b4.checkP); end
    endtask

    task automatic test_zero();
        int lat;
        load4(5, 5, 0, 0, 1, -1, 7, 7);
        run4(lat);
        n_checks++; if (lat != 4 || b4.sum !== 26'sd0 || b4.check !== 3'b001 || b4.checkP !== 2'd1) begin
            n_fail++; $display("FAIL zero_result: lat=%0d sum=%0d check=%b checkP=%0d expected 4 0 001 1", lat, b4.sum, b4.check, b4.checkP); end
    endtask

    task automatic test_full_scale();
        int lat;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 400; i++) begin
                b400.wr = 1'b1; b400.rs = 1'(s); b400.addr = 9'(i); b400.data = -8'sd128;
                tick();
            end
        end
        b400.wr = 1'b0;
        b400.start = 1'b1; tick(); b400.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 500; k++) begin
            tick();
            if (b400.done) begin lat = k; break; end
        end
        n_checks++; if (lat != 400) begin n_fail++; $display("FAIL full_latency: %0d expected 400", lat); end
        n_checks++; if (b400.sum !== 26'sd6553600 || b400.check !== 3'b010 || b400.checkP !== 2'd2) begin
            n_fail++; $display("FAIL full_result: sum=%0d check=%b checkP=%0d expected 6553600 010 2", b400.sum, b400.check, b400.checkP); end
    endtask

    task automatic test_ignored_inputs();
        int lat;
        int extra;
        load4(1, 2, 3, 4, 1, 1, 1, 1);
        b4.start = 1'b1; tick(); b4.start = 1'b0;
        // Write B[0] and re-start while RUN is in progress.
        b4.wr = 1'b1; b4.rs = 1'b1; b4.addr = 9'd0; b4.data = 8'sd100; b4.start = 1'b1;
        tick();
        b4.wr = 1'b0; b4.start = 1'b0;
        lat = -1;
        for (int k = 2; k <= 20; k++) begin tick(); if (b4.done) begin lat = k; break; end end
        n_checks++; if (lat != 4 || b4.sum !== 26'sd10) begin
            n_fail++; $display("FAIL run_inputs_ignored: lat=%0d sum=%0d expected 4 10", lat, b4.sum); end
        extra = 0;
        for (int k = 0; k < 8; k++) begin tick(); if (b4.done || b4.busy) extra++; end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL no_queued_run: %0d active cycles expected 0", extra); end
        write4(1'b0, 4, 50);
        run4(lat);
        n_checks++; if (b4.sum !== 26'sd10) begin n_fail++; $display("FAIL addr_n_ignored: sum=%0d expected 10", b4.sum); end
        b4.wr = 1'b1; b4.rs = 1'b0; b4.addr = 9'd0; b4.data = 8'sd9; b4.start = 1'b1;
        tick();
        b4.wr = 1'b0; b4.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin tick(); if (b4.done) begin lat = k; break; end end
        n_checks++; if (lat != 4 || b4.sum !== 26'sd18) begin
            n_fail++; $display("FAIL write_with_start: lat=%0d sum=%0d expected 4 18", lat, b4.sum); end
    endtask

    task automatic test_result_hold();
        load4(-1, -1, -1, -1, 1, 1, 1, 1);
        b4.start = 1'b1; tick(); b4.start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) begin
                n_checks++; if (b4.done !== 1'b0 || b4.sum !== 26'sd18 || b4.check !== 3'b010 || b4.checkP !== 2'd2) begin
                    n_fail++; $display("FAIL hold_k%0d: done=%b sum=%0d check=%b checkP=%0d expected 0 18 010 2", k, b4.done, b4.sum, b4.check, b4.checkP); end
            end else begin
                n_checks++; if (b4.done !== 1'b1 || b4.sum !== -26'sd4 || b4.check !== 3'b100 || b4.checkP !== 2'd3) begin
                    n_fail++; $display("FAIL hold_update: done=%b sum=%0d check=%b checkP=%0d expected 1 -4 100 3", b4.done, b4.sum, b4.check, b4.checkP); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        int pulses;
        load4(2, 2, 2, 2, 3, 3, 3, 3);
        first = -1; second = -1; pulses = 0;
        b4.start = 1'b1;
        tick();
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (b4.done) begin
                pulses++;
                if (first < 0) first = k; else second = k;
            end
        end
        b4.start = 1'b0;
        n_checks++; if (pulses != 2 || first != 4 || second != 9) begin
            n_fail++; $display("FAIL held_start: pulses=%0d at %0d,%0d expected 2 at 4,9", pulses, first, second); end
        n_checks++; if (b4.sum !== 26'sd24 || b4.checkP !== 2'd2) begin
            n_fail++; $display("FAIL held_start_sum: sum=%0d checkP=%0d expected 24 2", b4.sum, b4.checkP); end
        for (int k = 0; k < 6; k++) tick();
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1;
        b4.wr = 1'b0; b4.rs = 1'b0; b4.addr = '0; b4.data = '0; b4.start = 1'b0;
        b400.wr = 1'b0; b400.rs = 1'b0; b400.addr = '0; b400.data = '0; b400.start = 1'b0;
        test_reset();
        test_positive();
        test_negative();
        test_zero();
        test_full_scale();
        test_ignored_inputs();
        test_result_hold();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
